// File: rtl/seq_recognizer_param_if.sv
// Serial pattern recognizer bus: data/strobe/control in, pulse/count out.
// Optional SEQ_MASK_EN adds mask_in for don't-care pattern bits.
interface seq_recognizer_param_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic             in;
    logic             valid;
    logic             overlap;
    logic             pattern_load;
    logic [N-1:0]     pattern_in;
`ifdef SEQ_MASK_EN
    logic [N-1:0]     mask_in;
`endif
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

`ifdef SEQ_MASK_EN
    modport master (
        output in, valid, overlap, pattern_load,
        output pattern_in, mask_in,
        input  out, match_count, count_sat
    );
    modport slave (
        input  in, valid, overlap, pattern_load,
        input  pattern_in, mask_in,
        output out, match_count, count_sat
    );
`else
    modport master (
        output in, valid, overlap, pattern_load,
        output pattern_in,
        input  out, match_count, count_sat
    );
    modport slave (
        input  in, valid, overlap, pattern_load,
        input  pattern_in,
        output out, match_count, count_sat
    );
`endif
endinterface

// File: rtl/seq_recognizer_param.sv
// Parametrised serial sequence recognizer with loadable pattern.
// Optional SEQ_MASK_EN: masked compare using a loadable mask register.
module seq_recognizer_param #(
    parameter int             N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b011,
    parameter int             CNT_W   = 8
) (
    input logic                  clock,
    input logic                  reset,
    seq_recognizer_param_if.slave bus
);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]     pat;
    logic [N-1:0]     hist;
    logic [FW-1:0]    fill;
    logic             out_r;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     hist_next;
    logic [FW-1:0]    fill_next;
    logic             hit;
    logic             match;

`ifdef SEQ_MASK_EN
    logic [N-1:0]     msk;
`endif

    assign hist_next = {hist[N-2:0], bus.in};
    assign fill_next = (fill == FULL) ? FULL : fill + FW'(1);

`ifdef SEQ_MASK_EN
    assign hit = ((hist_next ^ pat) & msk) == '0;
`else
    assign hit = hist_next == pat;
`endif

    // fill guard keeps the zeroed history from matching e.g. pattern 000
    assign match = (fill_next == FULL) && hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            pat   <= PATTERN;
            hist  <= '0;
            fill  <= '0;
            out_r <= 1'b0;
            cnt   <= '0;
`ifdef SEQ_MASK_EN
            msk   <= '1;
`endif
        end else if (bus.pattern_load) begin
            pat   <= bus.pattern_in;
            hist  <= '0;
            fill  <= '0;
            out_r <= 1'b0;
            cnt   <= '0;
`ifdef SEQ_MASK_EN
            msk   <= bus.mask_in;
`endif
        end else if (bus.valid) begin
            hist  <= hist_next;
            out_r <= match;
            if (match) begin
                if (!(&cnt)) begin
                    cnt <= cnt + CNT_W'(1);
                end
                fill <= bus.overlap ? FULL : '0;
            end else begin
                fill <= fill_next;
            end
        end else begin
            out_r <= 1'b0;
        end
    end

    assign bus.out         = out_r;
    assign bus.match_count = cnt;
    assign bus.count_sat   = &cnt;
endmodule

// File: tb/tb_seq_recognizer_param.sv
// Randomised and directed bench for seq_recognizer_param.
// Reference model keeps a queue of received bits since the last clear.
module tb_seq_recognizer_param;
    localparam int           N       = 3;
    localparam int           CNT_W   = 2;
    localparam logic [N-1:0] PATTERN = 3'b011;
    localparam int           MAXC    = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;

    seq_recognizer_param_if #(.N(N), .CNT_W(CNT_W)) bus ();

    seq_recognizer_param #(
        .N(N), .PATTERN(PATTERN), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] m_pat;
    logic [N-1:0] m_msk;
    logic [N-1:0] drv_mask = '1;
    bit           q[$];
    int           m_since;
    bit           m_out;
    int           m_cnt;

    function automatic void model(input bit r, ld, v, b, ov,
                                  input logic [N-1:0] pin);
        bit hit;
        if (r || ld) begin
            m_pat   = r ? PATTERN : pin;
            m_msk   = r ? '1 : drv_mask;
            q.delete();
            m_since = 0;
            m_out   = 0;
            m_cnt   = 0;
        end else if (v) begin
            q.push_back(b);
            if (q.size() > N) void'(q.pop_front());
            m_since++;
            hit = 0;
            if (m_since >= N) begin
                hit = 1;
                for (int i = 0; i < N; i++)
                    if (m_msk[i] && q[q.size()-1-i] != m_pat[i])
                        hit = 0;
            end
            m_out = hit;
            if (hit) begin
                if (m_cnt < MAXC) m_cnt++;
                if (!ov) m_since = 0;
            end
        end else begin
            m_out = 0;
        end
    endfunction

    task automatic step(input bit r, ld, v, b, ov,
                        input logic [N-1:0] pin);
        reset            = r;
        bus.pattern_load = ld;
        bus.valid        = v;
        bus.in           = b;
        bus.overlap      = ov;
        bus.pattern_in   = pin;
`ifdef SEQ_MASK_EN
        bus.mask_in      = drv_mask;
`endif
        @(posedge clock);
        #1;
        model(r, ld, v, b, ov, pin);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, '0);
        tests++;
        if (bus.out !== 1'b0) begin
            fails++;
            $display("FAIL reset_out got %b want 0", bus.out);
        end
        tests++;
        if (bus.match_count !== '0) begin
            fails++;
            $display("FAIL reset_cnt got %0d want 0", bus.match_count);
        end
        tests++;
        if (bus.count_sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_sat got %b want 0", bus.count_sat);
        end
    endtask

    task automatic test_basic;
        bit s[6] = '{1, 0, 0, 0, 1, 1};
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, s[i], 0, '0);
            tests++;
            if (bus.out !== (i == 5)) begin
                fails++;
                $display("FAIL basic_out[%0d] got %b want %b",
                         i, bus.out, i == 5);
            end
        end
        tests++;
        if (bus.match_count !== 2'd1) begin
            fails++;
            $display("FAIL basic_cnt got %0d want 1", bus.match_count);
        end
    endtask

    task automatic test_overlap;
        bit s[5] = '{1, 0, 1, 0, 1};
        for (int ov = 1; ov >= 0; ov--) begin
            step(0, 1, 1, 1, 0, 3'b101);
            for (int i = 0; i < 5; i++) begin
                step(0, 0, 1, s[i], ov[0], '0);
                tests++;
                if (bus.out !== m_out ||
                    bus.out !== ((i == 2) || (ov == 1 && i == 4))) begin
                    fails++;
                    $display("FAIL ovl%0d_out[%0d] got %b model %b",
                             ov, i, bus.out, m_out);
                end
            end
            tests++;
            if (bus.match_count !== CNT_W'(ov + 1)) begin
                fails++;
                $display("FAIL ovl%0d_cnt got %0d want %0d",
                         ov, bus.match_count, ov + 1);
            end
        end
    endtask

    task automatic test_gap;
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, '0);
            tests++;
            if (bus.out !== 1'b0) begin
                fails++;
                $display("FAIL gap_out[%0d] got %b want 0", i, bus.out);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1, 0, '0);
            tests++;
            if (bus.out !== (i == 1)) begin
                fails++;
                $display("FAIL gap_tail[%0d] got %b want %b",
                         i, bus.out, i == 1);
            end
        end
    endtask

    task automatic test_saturate;
        int pulses = 0;
        bit g[3] = '{0, 1, 1};
        step(1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) begin
                step(0, 0, 1, g[i], 1, '0);
                if (bus.out === 1'b1) pulses++;
            end
            tests++;
            if (bus.match_count !== CNT_W'(k < 3 ? k + 1 : 3) ||
                bus.count_sat !== (k >= 2)) begin
                fails++;
                $display("FAIL sat_grp[%0d] cnt %0d sat %b want %0d %b",
                         k, bus.match_count, bus.count_sat,
                         k < 3 ? k + 1 : 3, k >= 2);
            end
        end
        tests++;
        if (pulses != 5) begin
            fails++;
            $display("FAIL sat_pulses got %0d want 5", pulses);
        end
    endtask

    task automatic test_zero_pattern;
        step(1, 0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, '0);
            tests++;
            if (bus.out !== (i == 2)) begin
                fails++;
                $display("FAIL zero_out[%0d] got %b want %b",
                         i, bus.out, i == 2);
            end
        end
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        tests++;
        if (bus.out !== 1'b0 || bus.match_count !== '0) begin
            fails++;
            $display("FAIL zero_rst out %b cnt %0d want 0 0",
                     bus.out, bus.match_count);
        end
        step(0, 0, 1, 1, 0, '0);
        tests++;
        if (bus.out !== 1'b0 || bus.match_count !== '0) begin
            fails++;
            $display("FAIL zero_post out %b cnt %0d want 0 0",
                     bus.out, bus.match_count);
        end
    endtask

    task automatic test_load_collision;
        bit s[3] = '{1, 0, 1};
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 0, 3'b101);
        tests++;
        if (bus.out !== 1'b0 || bus.match_count !== '0) begin
            fails++;
            $display("FAIL load_coll out %b cnt %0d want 0 0",
                     bus.out, bus.match_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, s[i], 0, '0);
            tests++;
            if (bus.out !== (i == 2)) begin
                fails++;
                $display("FAIL load_new[%0d] got %b want %b",
                         i, bus.out, i == 2);
            end
        end
`ifdef SEQ_MASK_EN
        drv_mask = 3'b101;
        step(0, 1, 0, 0, 0, 3'b101);
        drv_mask = '1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0, '0);
            tests++;
            if (bus.out !== (i == 2)) begin
                fails++;
                $display("FAIL mask_out[%0d] got %b want %b",
                         i, bus.out, i == 2);
            end
        end
`endif
    endtask

    task automatic test_random;
        bit r, ld, v, b, ov;
        logic [N-1:0] pin;
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            ld  = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            ov  = 1'($urandom);
            pin = N'($urandom);
`ifdef SEQ_MASK_EN
            drv_mask = N'($urandom);
`endif
            step(r, ld, v, b, ov, pin);
            tests++;
            if (bus.out !== m_out ||
                bus.match_count !== CNT_W'(m_cnt) ||
                bus.count_sat !== (m_cnt == MAXC)) begin
                fails++;
                $display("FAIL rand[%0d] out %b cnt %0d sat %b want %b %0d %b",
                         i, bus.out, bus.match_count, bus.count_sat,
                         m_out, m_cnt, m_cnt == MAXC);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.in           = 1'b0;
        bus.valid        = 1'b0;
        bus.overlap      = 1'b0;
        bus.pattern_load = 1'b0;
        bus.pattern_in   = '0;
`ifdef SEQ_MASK_EN
        bus.mask_in      = '1;
`endif
        test_reset;
        test_basic;
        test_overlap;
        test_gap;
        test_saturate;
        test_zero_pattern;
        test_load_collision;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
